// File: rtl/network_sequencer.sv
// network_sequencer: runs the spiking network through fixed-length inference
// windows. It buffers input samples in a FIFO and hands them to the network
// on its sample strobe. It accumulates output spikes per neuron across RUN
// and FLUSH, then presents the counts and the argmax class on a valid/ready
// result port.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   enable                     allow a new window to start (sampled in IDLE only)
//   s_valid/s_ready/s_data     sample input stream into the FIFO
//   net_ready                  network idle
//   net_start                  network run level (RUN and FLUSH)
//   net_sample                 network consumes the FIFO head this cycle
//   net_sample_ready           FIFO head valid for the network
//   net_in_spikes              FIFO head, zero when empty
//   net_out_spikes             per-cycle output spikes from the network
//   r_valid/r_ready            result handshake
//   r_class, r_counts          argmax index and packed per-neuron counts
//   busy                       sequencer not idle
//   err_underrun               network sampled an empty FIFO this/last window
module network_sequencer #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned N_OUT      = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WINDOW     = 8,
  parameter int unsigned NET_CYCLES = 10,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned CLS_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N_IN-1:0]        s_data,
  input  logic                   net_ready,
  output logic                   net_start,
  input  logic                   net_sample,
  output logic                   net_sample_ready,
  output logic [N_IN-1:0]        net_in_spikes,
  input  logic [N_OUT-1:0]       net_out_spikes,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [CLS_W-1:0]       r_class,
  output logic [N_OUT*CNT_W-1:0] r_counts,
  output logic                   busy,
  output logic                   err_underrun
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(WINDOW + 1);
  localparam int unsigned FW = $clog2(NET_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  logic [N_IN-1:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic [FCW-1:0]              r_fill;
  state_t                      r_state;
  logic [SW-1:0]               r_smp_cnt;
  logic [FW-1:0]               r_flush_cnt;
  logic [N_OUT-1:0][CNT_W-1:0] r_cnt;
  logic                        r_err;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_counting;
  logic [CLS_W-1:0] w_class;
  logic [CNT_W-1:0] w_best;

  assign w_empty    = (r_fill == '0);
  assign w_full     = (r_fill == FCW'(FIFO_DEPTH));
  assign w_push     = s_valid && !w_full;
  // Pops use the registered occupancy, so a same-cycle push never bypasses.
  assign w_pop      = (r_state == ST_RUN) && net_sample && !w_empty;
  assign w_counting = (r_state == ST_RUN) || (r_state == ST_FLUSH);

  // FIFO storage; contents need no reset since the head is gated when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FCW'(1);
        2'b01:   r_fill <= r_fill - FCW'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Window sequencing FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_smp_cnt   <= '0;
      r_flush_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && net_ready && !w_empty) r_state <= ST_START;
        end
        ST_START: begin
          r_smp_cnt <= '0;
          r_err     <= 1'b0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          if (net_sample) begin
            // An empty-FIFO sample still counts toward the window.
            if (w_empty) r_err <= 1'b1;
            r_smp_cnt <= r_smp_cnt + SW'(1);
            if (r_smp_cnt == SW'(WINDOW - 1)) begin
              r_flush_cnt <= '0;
              r_state     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == FW'(NET_CYCLES - 1)) r_state <= ST_DONE;
          else r_flush_cnt <= r_flush_cnt + FW'(1);
        end
        ST_DONE: begin
          if (r_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating per-neuron spike counters, cleared at window start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_cnt <= '0;
    end else if (w_counting) begin
      for (int i = 0; i < int'(N_OUT); i++) begin
        if (net_out_spikes[i] && (r_cnt[i] != {CNT_W{1'b1}}))
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Argmax; strict compare keeps ties on the lowest index.
  always_comb begin
    w_class = '0;
    w_best  = r_cnt[0];
    for (int i = 1; i < int'(N_OUT); i++) begin
      if (r_cnt[i] > w_best) begin
        w_best  = r_cnt[i];
        w_class = CLS_W'(i);
      end
    end
  end

  assign s_ready          = !w_full;
  assign net_start        = w_counting;
  assign net_sample_ready = (r_state == ST_RUN) && !w_empty;
  assign net_in_spikes    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign r_valid          = (r_state == ST_DONE);
  assign r_class          = w_class;
  assign r_counts         = r_cnt;
  assign busy             = (r_state != ST_IDLE);
  assign err_underrun     = r_err;

endmodule
